if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Decoupling stage between instruction fetch (IF) and decode (ID).
- Accepts instruction/PC pairs from IF with a valid/ready handshake and buffers them in a small circular queue.
- Presents the oldest entry to ID, so an ID stall never drops a fetched instruction.
- Supports a single-cycle flush on taken branch/jump redirect.

Parameters:
- INSTR_W, 32, width of instruction word and PC (matches `INSTR_WIDTH).
- DEPTH, 2, number of queue entries; power of two, 2..8.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  IF presents a valid instr/PC this cycle.
- in_ready  out  1  queue can accept an entry this cycle.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  INSTR_W  PC of fetched instruction.
- out_valid  out  1  head entry valid for ID.
- out_ready  in  1  ID consumes head this cycle (low = ID stall).
- out_instr  out  INSTR_W  head instruction; 32'h0000_0000 (NOP) when empty.
- out_pc  out  INSTR_W  head PC; 0 when empty.
- flush  in  1  redirect: discard queued entries.
- count  out  PTR_W+1  current occupancy, for debug/hazard logic.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH entries of {instr, pc}.
  - wr_ptr, rd_ptr are PTR_W bits and wrap modulo DEPTH.
  - cnt is PTR_W+1 bits, range 0..DEPTH.
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, cnt=0, so out_valid=0, out_instr=0, out_pc=0, in_ready=1, count=0.
  - Storage contents are not reset.
  - Reset asserted mid-transfer discards everything; no entry survives.
- in_ready = (cnt != DEPTH). Combinational from state only; it does not depend on out_ready (no pass-through).
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = (cnt != 0).
- Outputs: out_instr/out_pc are a combinational read of entry[rd_ptr] when cnt!=0, else zero.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
- Normal update (flush=0):
  - push only: write entry[wr_ptr], wr_ptr+1, cnt+1.
  - pop only: rd_ptr+1, cnt-1.
  - push & pop together: both pointers advance, cnt unchanged. This is legal at any cnt where in_ready=1.
  - When full, in_ready=0, so push is impossible; a pop in that cycle makes in_ready=1 only in the next cycle.
  - in_valid while in_ready=0: no write. IF must hold its data; the queue does not latch it.
- Flush (flush=1, without the optional feature):
  - Next state is cnt=0, rd_ptr=wr_ptr.
  - Any same-cycle push is discarded.
  - A same-cycle pop still completes toward ID (ID samples it this cycle).
- Flush has priority over push and pop for pointer/count update.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble; data order is strictly FIFO.
- count output = cnt.

Optional Feature:
- Macro: IF_ID_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot): on flush, exactly one entry is retained. It is the oldest instruction that would remain after this cycle's pop, considering the same-cycle push.
  - cnt - pop >= 1: keep that head (entry[rd_ptr+pop]); discard the rest; next cnt=1; new push discarded.
  - cnt - pop == 0 and push: write the pushed entry; next cnt=1.
  - Otherwise: next cnt=0.
- Not defined: flush empties the queue as in Behaviour; no retention logic is synthesised.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, out_instr=0, in_ready=1, count=0. After release, push instr=32'h2008_0005, pc=32'h0000_0000 -> next cycle out_valid=1, out_instr=32'h2008_0005, out_pc=0.
- Stall fill: out_ready=0, push pc=0x0,0x4,0x8 on consecutive cycles (DEPTH=2) -> in_ready=0 after second push, count=2, third not accepted. Raise out_ready -> outputs pc 0x0 then 0x4 then 0x8 in order.
- Streaming: in_valid=1, out_ready=1 continuously for 10 pushes -> count stays 1 after first, pointers wrap, out_pc sequence 0x0..0x24 in steps of 4 with no gaps.
- Flush (macro off): queue holds pc 0x10,0x14; assert flush with push pc 0x18 -> next cycle count=0, out_valid=0. Subsequent push pc 0x40 appears next.
- Flush (macro on): same stimulus with out_ready=0 -> count=1, out_pc=0x10. With out_ready=1 instead -> count=1, out_pc=0x14.
- Async reset mid-stream: drop rst between clock edges while count=2 -> out_valid falls immediately without a clock edge. After release, empty queue behaviour.

Source files
------------

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: circular buffer of {instr, pc} with valid/ready on both sides and redirect flush.
// Define IF_ID_DELAY_SLOT_EN to retain one delay-slot entry on flush.
module if_id_queue #(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [INSTR_W-1:0] in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_pc,
    input  logic               flush,
    output logic [PTR_W:0]     count
);

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [INSTR_W-1:0] mem_pc    [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [PTR_W:0]   cnt, cnt_next;
    logic             push, pop, we;

    assign in_ready  = (cnt != (PTR_W+1)'(DEPTH));
    assign out_valid = (cnt != '0);
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
    assign count     = cnt;

    always_comb begin
        push        = in_valid & in_ready;
        pop         = out_valid & out_ready;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        cnt_next    = cnt;
        we          = 1'b0;
        if (flush) begin
`ifdef IF_ID_DELAY_SLOT_EN
            // Keep the oldest survivor of this cycle's pop; fall back to the incoming entry if none remain.
            if ((cnt - (PTR_W+1)'(pop)) != '0) begin
                rd_ptr_next = rd_ptr + PTR_W'(pop);
                wr_ptr_next = rd_ptr + PTR_W'(pop) + PTR_W'(1);
                cnt_next    = (PTR_W+1)'(1);
            end else if (push) begin
                we          = 1'b1;
                rd_ptr_next = wr_ptr;
                wr_ptr_next = wr_ptr + PTR_W'(1);
                cnt_next    = (PTR_W+1)'(1);
            end else begin
                rd_ptr_next = wr_ptr;
                cnt_next    = '0;
            end
`else
            rd_ptr_next = wr_ptr;
            cnt_next    = '0;
`endif
        end else begin
            if (push) begin
                we          = 1'b1;
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_next = cnt + (PTR_W+1)'(1);
                2'b01:   cnt_next = cnt - (PTR_W+1)'(1);
                default: cnt_next = cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            cnt    <= cnt_next;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

endmodule
